ldst_issue_queue: RTL and testbench

In-order issue queue that sits directly upstream of the load/store unit. It accepts memory micro-ops from dispatch and holds them until their operands arrive on the two result broadcast buses. It computes the effective address (base + immediate) and issues one op per cycle, in program order, on the LSU request interface (`is_ld`/`data`/`location`/`ROBloc`/`input_valid`), honouring the LSU's `load_stall` back-pressure and the pipeline `flush`.

---
 rtl/ldst_issue_queue.sv | 129 ++++++++++++
 tb/tb_ldst_issue_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_issue_queue.sv
// In-order memory issue queue: holds dispatched load/store ops until their operands
// arrive on the broadcast buses, then issues them from the head one per cycle to the LSU.
module ldst_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        disp_valid,
  input  logic        disp_is_ld,
  input  logic [5:0]  disp_ROB,
  input  logic [15:0] disp_imm,
  input  logic        disp_base_rdy,
  input  logic [15:0] disp_base_val,
  input  logic [5:0]  disp_base_tag,
  input  logic        disp_data_rdy,
  input  logic [15:0] disp_data_val,
  input  logic [5:0]  disp_data_tag,
  output logic        disp_ready,
  input  logic        cdb0_valid,
  input  logic [5:0]  cdb0_ROB,
  input  logic [15:0] cdb0_data,
  input  logic        cdb1_valid,
  input  logic [5:0]  cdb1_ROB,
  input  logic [15:0] cdb1_data,
  input  logic        load_stall,
  output logic        is_ld,
  output logic [15:0] data,
  output logic [15:0] location,
  output logic [5:0]  ROBloc,
  output logic        input_valid
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic        rdy;
    logic [15:0] val;
    logic [5:0]  tag;
  } opnd_t;

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          ent_valid [DEPTH];
  logic          ent_is_ld [DEPTH];
  logic [5:0]    ent_rob   [DEPTH];
  logic [15:0]   ent_imm   [DEPTH];
  opnd_t         ent_base  [DEPTH];
  opnd_t         ent_data  [DEPTH];

  opnd_t disp_base, disp_data;
  logic  disp_acc, eligible, issue;

  // Bus 0 has priority when both buses carry the awaited tag.
  function automatic opnd_t wake(input opnd_t o);
    opnd_t r;
    r = o;
    if (!o.rdy) begin
      if (cdb0_valid && o.tag == cdb0_ROB) begin
        r.rdy = 1'b1;
        r.val = cdb0_data;
      end else if (cdb1_valid && o.tag == cdb1_ROB) begin
        r.rdy = 1'b1;
        r.val = cdb1_data;
      end
    end
    return r;
  endfunction

  assign disp_base  = '{rdy: disp_base_rdy, val: disp_base_val, tag: disp_base_tag};
  assign disp_data  = '{rdy: disp_data_rdy, val: disp_data_val, tag: disp_data_tag};
  assign disp_ready = (count < (PW+1)'(DEPTH));
  assign disp_acc   = disp_valid && disp_ready && !flush;
  assign eligible   = ent_valid[head] && ent_base[head].rdy &&
                      (ent_is_ld[head] || ent_data[head].rdy);
  assign issue      = eligible && !load_stall && !flush;

  // Control state and LSU request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      is_ld       <= 1'b0;
      data        <= '0;
      location    <= '0;
      ROBloc      <= '0;
      input_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_valid[i] <= 1'b0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      input_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_valid[i] <= 1'b0;
    end else begin
      input_valid <= issue;
      if (issue) begin
        is_ld          <= ent_is_ld[head];
        data           <= ent_is_ld[head] ? 16'h0000 : ent_data[head].val;
        location       <= ent_base[head].val + ent_imm[head];
        ROBloc         <= ent_rob[head];
        ent_valid[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      if (disp_acc) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      count <= count + (PW+1)'(disp_acc) - (PW+1)'(issue);
    end
  end

  // Entry payload: wakeup every cycle, dispatch write (with same-cycle bypass) at tail
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_base[i] <= wake(ent_base[i]);
      ent_data[i] <= wake(ent_data[i]);
    end
    if (disp_acc) begin
      ent_is_ld[tail] <= disp_is_ld;
      ent_rob[tail]   <= disp_ROB;
      ent_imm[tail]   <= disp_imm;
      ent_base[tail]  <= wake(disp_base);
      ent_data[tail]  <= wake(disp_data);
    end
  end

endmodule

// File: tb/tb_ldst_issue_queue.sv
// Scoreboard bench for ldst_issue_queue: a queue-level reference model predicts each
// LSU request; a monitor compares every presented request against the prediction.
module tb_ldst_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, disp_valid, disp_is_ld;
  logic [5:0]  disp_ROB;
  logic [15:0] disp_imm;
  logic        disp_base_rdy, disp_data_rdy;
  logic [15:0] disp_base_val, disp_data_val;
  logic [5:0]  disp_base_tag, disp_data_tag;
  logic        disp_ready;
  logic        cdb0_valid, cdb1_valid;
  logic [5:0]  cdb0_ROB, cdb1_ROB;
  logic [15:0] cdb0_data, cdb1_data;
  logic        load_stall;
  logic        is_ld, input_valid;
  logic [15:0] data, location;
  logic [5:0]  ROBloc;

  ldst_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_is_ld(disp_is_ld), .disp_ROB(disp_ROB), .disp_imm(disp_imm),
    .disp_base_rdy(disp_base_rdy), .disp_base_val(disp_base_val), .disp_base_tag(disp_base_tag),
    .disp_data_rdy(disp_data_rdy), .disp_data_val(disp_data_val), .disp_data_tag(disp_data_tag),
    .disp_ready(disp_ready),
    .cdb0_valid(cdb0_valid), .cdb0_ROB(cdb0_ROB), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_ROB(cdb1_ROB), .cdb1_data(cdb1_data),
    .load_stall(load_stall),
    .is_ld(is_ld), .data(data), .location(location), .ROBloc(ROBloc), .input_valid(input_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_ld;
    logic [5:0]  rob;
    logic [15:0] imm;
    logic        brdy;
    logic [15:0] bval;
    logic [5:0]  btag;
    logic        drdy;
    logic [15:0] dval;
    logic [5:0]  dtag;
  } mop_t;

  typedef struct {
    logic        is_ld;
    logic [15:0] data;
    logic [15:0] loc;
    logic [5:0]  rob;
  } exp_t;

  mop_t mq[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Operand capture from the buses as seen this cycle (bus 0 first)
  function automatic logic [16:0] wk(input logic rdy, input logic [15:0] val, input logic [5:0] tag);
    if (rdy) return {1'b1, val};
    if (cdb0_valid && tag == cdb0_ROB) return {1'b1, cdb0_data};
    if (cdb1_valid && tag == cdb1_ROB) return {1'b1, cdb1_data};
    return {1'b0, val};
  endfunction

  task automatic model_step();
    int   n;
    bit   acc;
    mop_t m;
    exp_t e;
    n   = mq.size();
    acc = disp_valid && (n < DEPTH);
    if (flush) begin
      mq.delete();
      return;
    end
    if (n > 0 && mq[0].brdy && (mq[0].is_ld || mq[0].drdy) && !load_stall) begin
      e.is_ld = mq[0].is_ld;
      e.data  = mq[0].is_ld ? 16'h0 : mq[0].dval;
      e.loc   = 16'(mq[0].bval + mq[0].imm);
      e.rob   = mq[0].rob;
      exp_q.push_back(e);
      void'(mq.pop_front());
    end
    for (int i = 0; i < mq.size(); i++) begin
      m = mq[i];
      {m.brdy, m.bval} = wk(m.brdy, m.bval, m.btag);
      {m.drdy, m.dval} = wk(m.drdy, m.dval, m.dtag);
      mq[i] = m;
    end
    if (acc) begin
      m.is_ld = disp_is_ld; m.rob = disp_ROB; m.imm = disp_imm;
      m.btag  = disp_base_tag; m.dtag = disp_data_tag;
      {m.brdy, m.bval} = wk(disp_base_rdy, disp_base_val, disp_base_tag);
      {m.drdy, m.dval} = wk(disp_data_rdy, disp_data_val, disp_data_tag);
      mq.push_back(m);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compare each presented request with the oldest prediction
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
      if (input_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: rob %h loc %h, none expected at %0t", ROBloc, location, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue_rob",   32'(ROBloc),   32'(e.rob));
          check("issue_is_ld", 32'(is_ld),    32'(e.is_ld));
          check("issue_loc",   32'(location), 32'(e.loc));
          check("issue_data",  32'(data),     32'(e.data));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_issue: input_valid 0, expected rob %h at %0t", e.rob, $time);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 0; disp_valid = 0; disp_is_ld = 0; disp_ROB = 0; disp_imm = 0;
    disp_base_rdy = 0; disp_base_val = 0; disp_base_tag = 0;
    disp_data_rdy = 0; disp_data_val = 0; disp_data_tag = 0;
    cdb0_valid = 0; cdb0_ROB = 0; cdb0_data = 0;
    cdb1_valid = 0; cdb1_ROB = 0; cdb1_data = 0;
  endtask

  task automatic disp(input logic ld, input logic [5:0] rob, input logic [15:0] imm,
                      input logic br, input logic [15:0] bv, input logic [5:0] bt,
                      input logic dr, input logic [15:0] dv, input logic [5:0] dt);
    disp_valid = 1; disp_is_ld = ld; disp_ROB = rob; disp_imm = imm;
    disp_base_rdy = br; disp_base_val = bv; disp_base_tag = bt;
    disp_data_rdy = dr; disp_data_val = dv; disp_data_tag = dt;
    @(negedge clk);
    disp_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    load_stall = 0;
    clear_inputs();
    #1;
    check("reset_disp_ready", 32'(disp_ready), 32'd1);
    check("reset_input_valid", 32'(input_valid), 32'd0);
    check("reset_outputs", {is_ld, data, ROBloc}, 32'd0);
    check("reset_location", 32'(location), 32'd0);
    idle(3);
    rst_n = 1;
    idle(1);

    // Ready load issues two edges after dispatch
    disp(1, 6'd5, 16'h0010, 1, 16'h1000, 0, 0, 0, 0);
    idle(3);

    // Store waiting on cdb1
    disp(0, 6'd7, 16'h0004, 1, 16'h2000, 0, 0, 0, 6'd3);
    idle(2);
    cdb1_valid = 1; cdb1_ROB = 6'd3; cdb1_data = 16'hBEEF;
    @(negedge clk);
    cdb1_valid = 0;
    idle(3);

    // Ready load behind a non-ready store waits
    disp(0, 6'd1, 16'h0000, 1, 16'h3000, 0, 0, 0, 6'd9);
    disp(1, 6'd2, 16'h0008, 1, 16'h4000, 0, 0, 0, 0);
    idle(2);
    cdb0_valid = 1; cdb0_ROB = 6'd9; cdb0_data = 16'h0055;
    @(negedge clk);
    cdb0_valid = 0;
    idle(4);

    // Fill under stall, fifth dispatch dropped, then drain with wrap
    load_stall = 1;
    for (int i = 0; i < 5; i++) disp(1, 6'(10 + i), 16'(i), 1, 16'h5000, 0, 0, 0, 0);
    check("full_disp_ready", 32'(disp_ready), 32'd0);
    load_stall = 0;
    idle(6);

    // Flush with queued ops, a CDB hit and a dispatch in the same cycle
    load_stall = 1;
    for (int i = 0; i < 3; i++) disp(0, 6'(20 + i), 16'h0, 1, 16'h6000, 0, 0, 0, 6'd4);
    flush = 1; cdb0_valid = 1; cdb0_ROB = 6'd4; cdb0_data = 16'h1234;
    disp(1, 6'd30, 16'h0, 1, 16'h7000, 0, 0, 0, 0);
    flush = 0; cdb0_valid = 0; load_stall = 0;
    check("flush_disp_ready", 32'(disp_ready), 32'd1);
    idle(2);
    disp(1, 6'd31, 16'h0002, 1, 16'h8000, 0, 0, 0, 0);
    idle(3);

    // Address wrap, then async reset while the request is valid
    disp(1, 6'd40, 16'h0002, 1, 16'hFFFF, 0, 0, 0, 0);
    disp(1, 6'd41, 16'h0000, 0, 16'h0, 6'd2, 0, 0, 0);
    check("wrap_valid_before_reset", 32'(input_valid), 32'd1);
    #1 rst_n = 0;
    #1;
    check("async_reset_valid", 32'(input_valid), 32'd0);
    check("async_reset_location", 32'(location), 32'd0);
    check("async_reset_disp_ready", 32'(disp_ready), 32'd1);
    #1 rst_n = 1;
    idle(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_is_ld    = $urandom_range(0, 1);
      disp_ROB      = 6'($urandom_range(0, 63));
      disp_imm      = 16'($urandom);
      disp_base_rdy = $urandom_range(0, 1);
      disp_base_val = 16'($urandom);
      disp_base_tag = 6'($urandom_range(0, 7));
      disp_data_rdy = $urandom_range(0, 1);
      disp_data_val = 16'($urandom);
      disp_data_tag = 6'($urandom_range(0, 7));
      cdb0_valid    = ($urandom_range(0, 9) < 4);
      cdb0_ROB      = 6'($urandom_range(0, 7));
      cdb0_data     = 16'($urandom);
      cdb1_valid    = ($urandom_range(0, 9) < 4);
      cdb1_ROB      = 6'($urandom_range(0, 7));
      cdb1_data     = 16'($urandom);
      load_stall    = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end

    clear_inputs();
    load_stall = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
